// File: rtl/miriscv_alu_arbiter.sv
// miriscv_alu_arbiter
// Shares one combinational miriscv ALU between two requesters. Operations
// arrive over valid/ready handshakes and are granted round-robin. The
// operator and operands are registered toward the ALU and held for
// EXEC_CYCLES cycles. The result is then captured and returned on a single
// tagged response channel.

module miriscv_alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [4:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [4:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,

    output logic [4:0]  alu_operator_o,
    output logic [31:0] alu_operand_a_o,
    output logic [31:0] alu_operand_b_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_comparison_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_flag_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Counter reload value; EXEC_CYCLES is limited to 1..15 so it fits in 4 bits.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    // True for the 16 operator codes the miriscv ALU implements.
    function automatic logic op_legal(input logic [4:0] op);
        logic legal;
        case (op)
            5'b00000, 5'b01000, 5'b00001, 5'b00010,
            5'b00011, 5'b00100, 5'b00101, 5'b01101,
            5'b00110, 5'b00111, 5'b11000, 5'b11001,
            5'b11100, 5'b11101, 5'b11110, 5'b11111: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        last_grant_r;
    logic        id_r;

    logic        grant_s;
    logic        accept_s;
    logic [4:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;

    // Round-robin grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Acceptance happens only in IDLE, so the two ready signals are mutually exclusive.
    always_comb begin
        accept_s     = (state_r == IDLE) && (req0_valid_i || req1_valid_i);
        req0_ready_o = accept_s && !grant_s && req0_valid_i;
        req1_ready_o = accept_s &&  grant_s && req1_valid_i;
    end

    // Operation mux feeding the ALU input registers.
    always_comb begin
        sel_op_s = req0_op_i;
        sel_a_s  = req0_a_i;
        sel_b_s  = req0_b_i;
        if (grant_s) begin
            sel_op_s = req1_op_i;
            sel_a_s  = req1_a_i;
            sel_b_s  = req1_b_i;
        end else begin
            sel_op_s = req0_op_i;
            sel_a_s  = req0_a_i;
            sel_b_s  = req0_b_i;
        end
    end

    // Control FSM: accept in IDLE, hold ALU inputs through EXEC, present the response in RESP.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r         <= IDLE;
            cnt_r           <= 4'd0;
            last_grant_r    <= 1'b1;
            id_r            <= 1'b0;
            alu_operator_o  <= 5'b00000;
            alu_operand_a_o <= 32'd0;
            alu_operand_b_o <= 32'd0;
            rsp_valid_o     <= 1'b0;
            rsp_id_o        <= 1'b0;
            rsp_result_o    <= 32'd0;
            rsp_flag_o      <= 1'b0;
            rsp_err_o       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        alu_operator_o  <= sel_op_s;
                        alu_operand_a_o <= sel_a_s;
                        alu_operand_b_o <= sel_b_s;
                        id_r            <= grant_s;
                        last_grant_r    <= grant_s;
                        cnt_r           <= CNT_INIT;
                        state_r         <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        if (op_legal(alu_operator_o)) begin
                            rsp_result_o <= alu_result_i;
                            rsp_flag_o   <= alu_comparison_i;
                            rsp_err_o    <= 1'b0;
                        end else begin
                            // Illegal operators never expose whatever the ALU produced.
                            rsp_result_o <= 32'd0;
                            rsp_flag_o   <= 1'b0;
                            rsp_err_o    <= 1'b1;
                        end
                        rsp_id_o    <= id_r;
                        rsp_valid_o <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    // The handshake cycle only retires the response; IDLE accepts on the next one.
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// Testbench for miriscv_alu_arbiter. Instance A uses EXEC_CYCLES=1 and
// instance B uses EXEC_CYCLES=4. Both share the requester stimulus, and each
// instance is held in reset while the other one is exercised. A reference
// ALU model drives each alu_result_i from that instance's alu_*_o.

module tb_miriscv_alu_arbiter;

    logic        clk;
    logic        arstn_a;
    logic        arstn_b;

    logic        r0_valid;
    logic [4:0]  r0_op;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic        r1_valid;
    logic [4:0]  r1_op;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic        rsp_ready;

    logic        a_rdy0, a_rdy1, a_rsp_valid, a_rsp_id, a_rsp_flag, a_rsp_err, a_cmp;
    logic [4:0]  a_alu_op;
    logic [31:0] a_alu_a, a_alu_b, a_res, a_rsp_result;
    logic        b_rdy0, b_rdy1, b_rsp_valid, b_rsp_id, b_rsp_flag, b_rsp_err, b_cmp;
    logic [4:0]  b_alu_op;
    logic [31:0] b_alu_a, b_alu_b, b_res, b_rsp_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    // Reference miriscv ALU; illegal codes return junk so that result forcing is observable.
    function automatic logic [32:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        case (op)
            5'b00000: r = {1'b0, a + b};
            5'b01000: r = {1'b0, a - b};
            5'b00100: r = {1'b0, a ^ b};
            5'b00110: r = {1'b0, a | b};
            5'b00111: r = {1'b0, a & b};
            5'b00001: r = {1'b0, a << b[4:0]};
            5'b00101: r = {1'b0, a >> b[4:0]};
            5'b01101: r = {1'b0, $unsigned($signed(a) >>> b[4:0])};
            5'b00010: r = {1'b0, 31'd0, ($signed(a) < $signed(b))};
            5'b00011: r = {1'b0, 31'd0, (a < b)};
            5'b11000: r = {(a == b), 32'd0};
            5'b11001: r = {(a != b), 32'd0};
            5'b11100: r = {($signed(a) < $signed(b)), 32'd0};
            5'b11101: r = {($signed(a) >= $signed(b)), 32'd0};
            5'b11110: r = {(a < b), 32'd0};
            5'b11111: r = {(a >= b), 32'd0};
            default:  r = {1'b1, 32'hDEADBEEF};
        endcase
        return r;
    endfunction

    assign {a_cmp, a_res} = alu_model(a_alu_op, a_alu_a, a_alu_b);
    assign {b_cmp, b_res} = alu_model(b_alu_op, b_alu_a, b_alu_b);

    miriscv_alu_arbiter #(.EXEC_CYCLES(1)) dut_a (
        .clk_i(clk), .arstn_i(arstn_a),
        .req0_valid_i(r0_valid), .req0_ready_o(a_rdy0), .req0_op_i(r0_op), .req0_a_i(r0_a), .req0_b_i(r0_b),
        .req1_valid_i(r1_valid), .req1_ready_o(a_rdy1), .req1_op_i(r1_op), .req1_a_i(r1_a), .req1_b_i(r1_b),
        .alu_operator_o(a_alu_op), .alu_operand_a_o(a_alu_a), .alu_operand_b_o(a_alu_b),
        .alu_result_i(a_res), .alu_comparison_i(a_cmp),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(a_rsp_id),
        .rsp_result_o(a_rsp_result), .rsp_flag_o(a_rsp_flag), .rsp_err_o(a_rsp_err)
    );

    miriscv_alu_arbiter #(.EXEC_CYCLES(4)) dut_b (
        .clk_i(clk), .arstn_i(arstn_b),
        .req0_valid_i(r0_valid), .req0_ready_o(b_rdy0), .req0_op_i(r0_op), .req0_a_i(r0_a), .req0_b_i(r0_b),
        .req1_valid_i(r1_valid), .req1_ready_o(b_rdy1), .req1_op_i(r1_op), .req1_a_i(r1_a), .req1_b_i(r1_b),
        .alu_operator_o(b_alu_op), .alu_operand_a_o(b_alu_a), .alu_operand_b_o(b_alu_b),
        .alu_result_i(b_res), .alu_comparison_i(b_cmp),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(b_rsp_id),
        .rsp_result_o(b_rsp_result), .rsp_flag_o(b_rsp_flag), .rsp_err_o(b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single-requester transaction on instance A (EXEC_CYCLES=1), exact cycle timing.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        r0_valid = !v.id; r1_valid = v.id;
        r0_op = v.op; r0_a = v.a; r0_b = v.b;
        r1_op = v.op; r1_a = v.a; r1_b = v.b;
        #1;
        chk("vec_ready_sel",   v.id ? a_rdy1 : a_rdy0, 32'd1);
        chk("vec_ready_other", v.id ? a_rdy0 : a_rdy1, 32'd0);
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_op = 5'b00000; r1_op = 5'b00000; r0_a = 32'd0; r1_a = 32'd0;
        chk("vec_exec_no_rsp", a_rsp_valid, 32'd0);
        chk("vec_alu_op", a_alu_op, v.op);
        chk("vec_alu_a", a_alu_a, v.a);
        @(negedge clk);
        chk("vec_rsp_valid", a_rsp_valid, 32'd1);
        chk("vec_rsp_id", a_rsp_id, v.id);
        chk("vec_rsp_result", a_rsp_result, v.res);
        chk("vec_rsp_flag", a_rsp_flag, v.flag);
        chk("vec_rsp_err", a_rsp_err, v.err);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("vec_rsp_drop", a_rsp_valid, 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'b00000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'b01000, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'b10000, 32'd1,          32'd2,          32'd0,          1'b0, 1'b1};
        vecs[3] = '{1'b0, 5'b11000, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'b00011, 32'd1,          32'd2,          32'd1,          1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'b00010, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0};
        vecs[6] = '{1'b0, 5'b00101, 32'h80000000,   32'd4,          32'h08000000,   1'b0, 1'b0};
        vecs[7] = '{1'b1, 5'b01001, 32'd5,          32'd5,          32'd0,          1'b0, 1'b1};
        vecs[8] = '{1'b0, 5'b11111, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0};
        vecs[9] = '{1'b1, 5'b00001, 32'd1,          32'd31,         32'h80000000,   1'b0, 1'b0};

        arstn_a = 1'b0; arstn_b = 1'b0;
        r0_valid = 1'b0; r0_op = 5'b00000; r0_a = 32'd0; r0_b = 32'd0;
        r1_valid = 1'b0; r1_op = 5'b00000; r1_a = 32'd0; r1_b = 32'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_alu_op", a_alu_op, 32'd0);
        chk("rst_alu_a", a_alu_a, 32'd0);
        chk("rst_alu_b", a_alu_b, 32'd0);
        chk("rst_rsp_valid", a_rsp_valid, 32'd0);
        chk("rst_rsp_id", a_rsp_id, 32'd0);
        chk("rst_rsp_result", a_rsp_result, 32'd0);
        chk("rst_rsp_flag", a_rsp_flag, 32'd0);
        chk("rst_rsp_err", a_rsp_err, 32'd0);
        arstn_a = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Contention from reset: req0 first, then req1, then req0 again
        @(negedge clk); arstn_a = 1'b0;
        @(negedge clk); arstn_a = 1'b1;
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 5'b01000; r0_a = 32'd3;          r0_b = 32'd5;
        r1_valid = 1'b1; r1_op = 5'b11100; r1_a = 32'hFFFFFFFF;   r1_b = 32'd1;
        #1;
        chk("cont_rdy0", a_rdy0, 32'd1);
        chk("cont_rdy1", a_rdy1, 32'd0);
        @(negedge clk); r0_valid = 1'b0;
        chk("cont_exec_rdy1", a_rdy1, 32'd0);
        @(negedge clk);
        chk("cont_rsp0_valid", a_rsp_valid, 32'd1);
        chk("cont_rsp0_id", a_rsp_id, 32'd0);
        chk("cont_rsp0_result", a_rsp_result, 32'hFFFFFFFE);
        rsp_ready = 1'b1; #1;
        chk("cont_hs_no_accept", a_rdy1, 32'd0);
        @(negedge clk); rsp_ready = 1'b0; #1;
        chk("cont_rsp0_drop", a_rsp_valid, 32'd0);
        chk("cont_rdy1_idle", a_rdy1, 32'd1);
        @(negedge clk); r1_valid = 1'b0;
        @(negedge clk);
        chk("cont_rsp1_id", a_rsp_id, 32'd1);
        chk("cont_rsp1_flag", a_rsp_flag, 32'd1);
        chk("cont_rsp1_result", a_rsp_result, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_op = 5'b00000; r0_a = 32'd1; r0_b = 32'd1;
        r1_valid = 1'b1; r1_op = 5'b00000; r1_a = 32'd2; r1_b = 32'd2;
        #1;
        chk("fair_rdy0", a_rdy0, 32'd1);
        chk("fair_rdy1", a_rdy1, 32'd0);
        @(negedge clk); r0_valid = 1'b0;
        @(negedge clk);
        chk("fair_rsp_a", a_rsp_result, 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        chk("fair_rdy1_next", a_rdy1, 32'd1);
        @(negedge clk); r1_valid = 1'b0;
        @(negedge clk);
        chk("fair_rsp_b_id", a_rsp_id, 32'd1);
        chk("fair_rsp_b", a_rsp_result, 32'd4);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;

        // Back-pressure: response held 4+ cycles while req1 waits
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 5'b00000; r0_a = 32'd10; r0_b = 32'd20;
        #1; chk("bp_rdy0", a_rdy0, 32'd1);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_op = 5'b00110; r1_a = 32'hF0; r1_b = 32'h0F;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid_hold", a_rsp_valid, 32'd1);
            chk("bp_result_hold", a_rsp_result, 32'd30);
            chk("bp_id_hold", a_rsp_id, 32'd0);
            chk("bp_no_rdy1", a_rdy1, 32'd0);
            chk("bp_no_rdy0", a_rdy0, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1; #1;
        chk("bp_hs_no_accept", a_rdy1, 32'd0);
        @(negedge clk); rsp_ready = 1'b0; #1;
        chk("bp_pending_accept", a_rdy1, 32'd1);
        @(negedge clk); r1_valid = 1'b0;
        @(negedge clk);
        chk("bp_rsp1_result", a_rsp_result, 32'hFF);
        chk("bp_rsp1_id", a_rsp_id, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;

        // Instance B: EXEC_CYCLES=4, SRA
        arstn_a = 1'b0; arstn_b = 1'b1;
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 5'b01101; r0_a = 32'h80000000; r0_b = 32'd4;
        #1; chk("b_rdy0", b_rdy0, 32'd1);
        @(negedge clk);
        r0_valid = 1'b0; r0_op = 5'b00000; r0_a = 32'd0; r0_b = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk("b_hold_op", b_alu_op, 32'h0D);
            chk("b_hold_a", b_alu_a, 32'h80000000);
            chk("b_hold_b", b_alu_b, 32'd4);
            chk("b_no_rsp", b_rsp_valid, 32'd0);
            @(negedge clk);
        end
        chk("b_rsp_valid", b_rsp_valid, 32'd1);
        chk("b_rsp_result", b_rsp_result, 32'hF8000000);
        chk("b_rsp_flag", b_rsp_flag, 32'd0);
        chk("b_rsp_err", b_rsp_err, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;

        // Instance B: reset mid-EXEC discards the op and restores grant priority
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 5'b00000; r0_a = 32'd1; r0_b = 32'd2;
        #1; chk("rst_mid_rdy0", b_rdy0, 32'd1);
        @(negedge clk); r0_valid = 1'b0;
        chk("rst_mid_alu_a", b_alu_a, 32'd1);
        @(negedge clk);
        #1; arstn_b = 1'b0; #1;
        chk("rst_mid_op", b_alu_op, 32'd0);
        chk("rst_mid_a", b_alu_a, 32'd0);
        chk("rst_mid_b", b_alu_b, 32'd0);
        chk("rst_mid_valid", b_rsp_valid, 32'd0);
        chk("rst_mid_result", b_rsp_result, 32'd0);
        @(negedge clk); arstn_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", b_rsp_valid, 32'd0);
        end
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        chk("rst_mid_grant0", b_rdy0, 32'd1);
        chk("rst_mid_grant1", b_rdy1, 32'd0);
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/miriscv_alu_arbiter.md
Name: miriscv_alu_arbiter

Overview:
- Shares one combinational miriscv ALU between two requesters, e.g. req0 = main execute stage and req1 = address/branch helper unit.
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Registers the operator and operands that drive the shared ALU, holds them for a configurable number of execute cycles, captures the result, and returns it through a single tagged response channel.

Parameters:
- EXEC_CYCLES, 1, cycles the ALU inputs are held stable before the result is captured; legal range 1..15.

Ports:
- clk_i  input  1  clock, all state on rising edge
- arstn_i  input  1  asynchronous active-low reset
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_op_i  input  5  requester 0 ALU operator code
- req0_a_i  input  32  requester 0 operand A
- req0_b_i  input  32  requester 0 operand B
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i  same as requester 0, for requester 1
- alu_operator_o  output  5  to shared ALU operator input
- alu_operand_a_o  output  32  to shared ALU operand A
- alu_operand_b_o  output  32  to shared ALU operand B
- alu_result_i  input  32  from shared ALU result
- alu_comparison_i  input  1  from shared ALU comparison flag
- rsp_valid_o  output  1  response available
- rsp_ready_i  input  1  consumer takes response
- rsp_id_o  output  1  requester index of the response
- rsp_result_o  output  32  captured ALU result
- rsp_flag_o  output  1  captured comparison flag
- rsp_err_o  output  1  operator code was not one of the 16 legal ALU codes

Behaviour:
- Reset (arstn_i low, asynchronous, any state): state=IDLE; alu_operator_o=5'b00000; alu_operand_a_o=0; alu_operand_b_o=0; rsp_valid_o=0; rsp_id_o=0; rsp_result_o=0; rsp_flag_o=0; rsp_err_o=0; exec counter=0; last_grant=1, so req0 wins the first contention. An operation in flight is discarded; no response is produced for it.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one valid: grant that requester.
  - Both valid: grant the requester other than last_grant.
- IDLE, acceptance:
  - reqN_ready_o is combinational: 1 only in IDLE, only for the granted N, and only while reqN_valid_i=1. Both ready signals are never high together.
  - On acceptance: latch op/a/b into the alu_*_o registers, latch id, set last_grant=N, load counter=EXEC_CYCLES-1, go to EXEC.
- EXEC: alu_*_o hold constant. When the counter is 0: capture alu_result_i→rsp_result_o and alu_comparison_i→rsp_flag_o, set rsp_err_o, set rsp_valid_o=1, go to RESP. Otherwise decrement the counter.
- Legal operator codes for rsp_err_o: 00000, 01000, 00001, 00010, 00011, 00100, 00101, 01101, 00110, 00111, 11000, 11001, 11100, 11101, 11110, 11111. Any other code sets rsp_err_o=1 and forces rsp_result_o=0 and rsp_flag_o=0.
- RESP:
  - rsp_* are stable while rsp_valid_o=1 and rsp_ready_i=0.
  - On rsp_ready_i=1: rsp_valid_o=0 next cycle, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: accept edge to rsp_valid_o high = EXEC_CYCLES+1 cycles. Minimum issue interval = EXEC_CYCLES+2 cycles, given rsp_ready_i held high.
- alu_*_o keep their last values in IDLE and RESP; they change only on acceptance.
- Requester inputs are ignored outside the acceptance cycle. A requester may drop valid before it is granted without side effect.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Test Plan:
- Reset, then req0 op=00000 a=5 b=7 with EXEC_CYCLES=1 → req0_ready_o=1 in the accept cycle; rsp_valid_o rises 2 cycles later with rsp_id_o=0, rsp_result_o=12, rsp_flag_o=0, rsp_err_o=0.
- Both valid from reset: req0 op=01000 a=3 b=5, req1 op=11100 a=0xFFFFFFFF b=1 → req0 served first with result 0xFFFFFFFE; req1 served next with flag=1, result=0; the following contention is granted to req0.
- Consumer holds rsp_ready_i=0 for 4 cycles → rsp_* stable, no readyN asserted; rsp_ready_i=1 → IDLE, pending request accepted the next cycle.
- Illegal op 5'b10000 on req1 → rsp_err_o=1, rsp_result_o=0, rsp_flag_o=0, rsp_id_o=1.
- EXEC_CYCLES=4, op=01101 a=0x80000000 b=4 → alu_*_o stable for 4 cycles; result 0xF8000000 after 5 cycles.
- arstn_i pulsed low mid-EXEC → all outputs return to reset values immediately; no response emitted; next contention grants req0.
